// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush scheduler for the 5-stage MIPS pipeline.
// Inputs:  clk, rst (async, active-low), fetch_busy, id_stall_req,
//          ex_div_start, mem_busy, exc_eret/syscall/break/overflow,
//          exc_delayslot, exc_pc, cp0_epc.
// Outputs: stall[4:0] (PC, IF/ID, ID/EX, EX/MEM, MEM/WB), flush, flush_pc,
//          exc_commit, exc_cause, exc_epc, exc_bd, div_done.
// Optional: define PIPELINE_CTRL_PERF_EN to add perf_stall_cycles and
//           perf_flush_count.
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] EXC_BASE = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_busy,
    input  logic                  id_stall_req,
    input  logic                  ex_div_start,
    input  logic                  mem_busy,
    input  logic                  exc_eret,
    input  logic                  exc_syscall,
    input  logic                  exc_break,
    input  logic                  exc_overflow,
    input  logic                  exc_delayslot,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic [ADDR_WIDTH-1:0] cp0_epc,
    output logic [4:0]            stall,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  exc_commit,
    output logic [4:0]            exc_cause,
    output logic [ADDR_WIDTH-1:0] exc_epc,
    output logic                  exc_bd,
    output logic                  div_done
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [15:0]           perf_flush_count
`endif
);

    localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_BUSY,
        EXC_FLUSH
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;
    logic                  commit_q, commit_d;
    logic [4:0]            cause_q, cause_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic                  bd_q, bd_d;

    logic       exc_flag;
    logic       exc_any;
    logic       div_stall;
    logic       div_fin;
    logic [4:0] stall_v;

    // A pending exception waits behind a data-bus stall; the MEM stall
    // keeps its flags in place until the bus is free.
    assign exc_flag = exc_eret | exc_syscall | exc_break | exc_overflow;
    assign exc_any  = exc_flag & (state_q != EXC_FLUSH) & ~mem_busy;

    assign div_stall = ((state_q == IDLE) & ex_div_start)
                     | ((state_q == DIV_BUSY) & ((cnt_q != '0) | mem_busy));

    assign div_fin = (state_q == DIV_BUSY) & (cnt_q == '0)
                   & ~mem_busy & ~exc_any;

    // Stage k stalls every register upstream of it, so the deepest active
    // source sets the width of the ones-run.
    always_comb begin
        stall_v = 5'b00000;
        if (fetch_busy)   stall_v = 5'b00001;
        if (id_stall_req) stall_v = 5'b00011;
        if (div_stall)    stall_v = 5'b00111;
        if (mem_busy)     stall_v = 5'b01111;
        if (exc_any)      stall_v = 5'b11111;
        if (state_q == EXC_FLUSH) stall_v = 5'b00000;
    end

    // Combinational outputs are forced quiet while reset is held.
    assign stall    = rst ? stall_v : 5'b00000;
    assign div_done = rst & div_fin;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        commit_d   = 1'b0;
        flush_pc_d = flush_pc_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        bd_d       = bd_q;

        unique case (state_q)
            IDLE: begin
                if (ex_div_start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            DIV_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!mem_busy) begin
                    state_d = IDLE;
                end
            end
            EXC_FLUSH: state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        // Exception entry overrides a divide start or an in-flight divide.
        if (exc_any) begin
            state_d    = EXC_FLUSH;
            cnt_d      = '0;
            flush_d    = 1'b1;
            commit_d   = ~exc_eret;
            flush_pc_d = exc_eret ? cp0_epc : EXC_BASE;
            if (exc_eret)         cause_d = 5'd0;
            else if (exc_syscall) cause_d = 5'd8;
            else if (exc_break)   cause_d = 5'd9;
            else                  cause_d = 5'd12;
            epc_d = exc_delayslot ? exc_pc - ADDR_WIDTH'(4) : exc_pc;
            bd_d  = exc_delayslot;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= EXC_BASE;
            commit_q   <= 1'b0;
            cause_q    <= 5'd0;
            epc_q      <= '0;
            bd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
            commit_q   <= commit_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
        end
    end

    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;
    assign exc_commit = commit_q;
    assign exc_cause  = cause_q;
    assign exc_epc    = epc_q;
    assign exc_bd     = bd_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_v[0] && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 1'b1;
            if (flush_q)
                perf_flush_q <= perf_flush_q + 1'b1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Collects stall requests from IF, ID, EX (multi-cycle divide) and MEM (data bus wait), plus exception flags arriving at MEM.
- Drives the per-register stall vector and the common flush used by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). Each register takes stall[i] as stall_current_stage and stall[i+1] as stall_next_stage; stall[5] is tied 0.
- Sequences exception entry and ERET: one-cycle freeze, then a registered flush with redirect PC and a CP0 commit pulse.

Parameters:
- DIV_CYCLES, 32, total EX stall cycles for a divide (must be >= 2).
- EXC_BASE, 32'hBFC00380, exception vector address.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- fetch_busy  in  1  instruction bus not ready.
- id_stall_req  in  1  load-use hazard in ID.
- ex_div_start  in  1  EX holds a div/divu.
- mem_busy  in  1  data bus not ready.
- exc_eret, exc_syscall, exc_break, exc_overflow  in  1 each  flags from EX/MEM outputs.
- exc_delayslot  in  1  MEM instruction is in a delay slot.
- exc_pc  in  ADDR_WIDTH  PC of the MEM instruction.
- cp0_epc  in  ADDR_WIDTH  current EPC.
- stall  out  5  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB.
- flush  out  1  clear all pipeline registers.
- flush_pc  out  ADDR_WIDTH  redirect target, valid while flush=1.
- exc_commit  out  1  write Cause/EPC/Status.EXL to CP0.
- exc_cause  out  5  ExcCode.
- exc_epc  out  ADDR_WIDTH  EPC value to write.
- exc_bd  out  1  Cause.BD.
- div_done  out  1  divide result valid this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - All outputs 0, except flush_pc=EXC_BASE.
- States: IDLE, DIV_BUSY, EXC_FLUSH.
- Exception detect: exc_any = any exc_* flag, and state != EXC_FLUSH, and mem_busy=0.
  - If mem_busy=1, the exception waits; the MEM stall holds the flags.
- Stall vector is combinational. Sources are ORed, and stage k stalls registers 0..k:
  - fetch_busy -> stall[0].
  - id_stall_req -> stall[1:0].
  - div stall -> stall[2:0].
  - mem_busy -> stall[3:0].
  - exc_any -> stall[4:0] (freeze cycle).
  - In EXC_FLUSH, stall = 0.
- Div stall is active when:
  - state=IDLE and ex_div_start=1 (start cycle), or
  - state=DIV_BUSY and cnt != 0, or
  - state=DIV_BUSY and mem_busy=1.
- IDLE:
  - exc_any -> EXC_FLUSH. Latch cause, target, epc and bd.
  - Else ex_div_start -> DIV_BUSY with cnt = DIV_CYCLES-1.
- DIV_BUSY:
  - cnt decrements each cycle while nonzero.
  - At cnt=0 and mem_busy=0: div_done=1 for one cycle, stall released, -> IDLE.
  - ex_div_start is ignored in DIV_BUSY.
  - exc_any aborts: cnt=0, -> EXC_FLUSH.
  - Total stalled cycles = DIV_CYCLES (no mem_busy).
- EXC_FLUSH (exactly one cycle):
  - flush=1, flush_pc=latched target, then -> IDLE.
  - Non-ERET: exc_commit=1 with latched exc_cause, exc_epc, exc_bd.
  - ERET: exc_commit=0.
- Priority among simultaneous flags: eret > syscall > break > overflow.
  - ExcCode: Sys=8, Bp=9, Ov=12.
  - ERET target = cp0_epc; otherwise EXC_BASE.
- exc_epc = exc_delayslot ? exc_pc-4 : exc_pc (ADDR_WIDTH wrap-around arithmetic). exc_bd = exc_delayslot.
- Registered outputs (flush, flush_pc, exc_*) hold their values outside EXC_FLUSH. Only flush, exc_commit and div_done are pulses.
- Reset mid-divide or mid-flush returns to IDLE immediately; no pending state survives.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles (32 bits) and perf_flush_count (16 bits), both reset to 0.
  - perf_stall_cycles increments every cycle stall[0]=1, saturating.
  - perf_flush_count increments on each flush, wrapping.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: id_stall_req=1 for 1 cycle -> stall=5'b00011 for that cycle, then 0; flush stays 0.
- Divide, DIV_CYCLES=32: ex_div_start pulse held -> stall=5'b00111 for exactly 32 cycles; div_done=1 in cycle 33 with stall=0.
- Syscall, exc_pc=0x80001000, delayslot=1, mem_busy high for 3 cycles:
  - stall=5'b01111 for 3 cycles, then one cycle 5'b11111.
  - Next cycle: flush=1, flush_pc=0xBFC00380, exc_commit=1, exc_cause=8, exc_epc=0x80000FFC, exc_bd=1.
- ERET together with overflow, cp0_epc=0x80002000 -> flush_pc=0x80002000, exc_commit=0.
- Overflow at divide cycle 10 -> div abandoned, flush next cycle, div_done never asserted, state returns to IDLE.
- rst=0 asserted mid-divide (cnt=15) -> stall=0, div_done=0, flush=0 immediately; after release, ex_div_start=0 gives no stall.
